// File: rtl/ov7670_frame_capture.sv
// OV7670 RGB565 capture: pairs sensor bytes into pixels and writes them into the frame buffer.
// Discards the first SKIP_FRAMES frames after reset and reports per-frame completeness.
//
// state  | meaning
// SYNC   | after reset, waiting for the first vsync rising edge
// VBLANK | vertical blanking, waiting for vsync to fall
// SKIP   | settling frame after reset, bytes ignored
// ACTIVE | frame being captured into the buffer
module ov7670_frame_capture #(
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int ADDR_W      = 17,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              capturing
);

    localparam int TOTAL  = H_PIXELS * V_LINES;
    localparam int X_W    = ($clog2(H_PIXELS + 1) > 9) ? $clog2(H_PIXELS + 1) : 9;
    localparam int Y_W    = ($clog2(V_LINES + 1) > 8) ? $clog2(V_LINES + 1) : 8;
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [X_W-1:0]    X_LIMIT   = X_W'(H_PIXELS);
    localparam logic [Y_W-1:0]    Y_LIMIT   = Y_W'(V_LINES);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(TOTAL);
    localparam logic [ADDR_W-1:0] PIX_MAX   = '1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);

    typedef enum logic [1:0] {SYNC, VBLANK, SKIP, ACTIVE} state_t;

    state_t            state;
    logic              vsync_d;
    logic              href_d;
    logic [SKIP_W-1:0] skip_cnt;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              phase;
    logic [7:0]        byte0;
    logic [ADDR_W-1:0] pix_cnt;
    logic [ADDR_W-1:0] line_base;

    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;

    assign vsync_rise = cam_vsync & ~vsync_d;
    assign vsync_fall = ~cam_vsync & vsync_d;
    assign href_fall  = ~cam_href & href_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            skip_cnt   <= SKIP_INIT;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            byte0      <= '0;
            pix_cnt    <= '0;
            line_base  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            capturing  <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;

            case (state)
                SYNC: begin
                    if (vsync_rise) state <= VBLANK;
                end
                VBLANK: begin
                    if (vsync_fall) begin
                        if (skip_cnt != '0) begin
                            skip_cnt <= skip_cnt - 1'b1;
                            state    <= SKIP;
                        end else begin
                            state     <= ACTIVE;
                            capturing <= 1'b1;
                            x         <= '0;
                            y         <= '0;
                            phase     <= 1'b0;
                            pix_cnt   <= '0;
                            line_base <= '0;
                        end
                    end
                end
                SKIP: begin
                    if (vsync_rise) state <= VBLANK;
                end
                ACTIVE: begin
                    // Frame end wins over any byte sampled in the same cycle.
                    if (vsync_rise) begin
                        state      <= VBLANK;
                        capturing  <= 1'b0;
                        frame_done <= 1'b1;
                        frame_ok   <= (pix_cnt == PIX_TOTAL);
                    end else if (cam_href) begin
                        if (!phase) begin
                            byte0 <= cam_data;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (x < X_LIMIT && y < Y_LIMIT) begin
                                wr_en   <= 1'b1;
                                wr_addr <= line_base + ADDR_W'(x);
                                wr_data <= {byte0, cam_data};
                                x       <= x + 1'b1;
                                if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        // Line base only advances while another buffer line exists.
                        if (x != '0) begin
                            if (y < Y_LIMIT) y <= y + 1'b1;
                            if (y < Y_LAST) line_base <= line_base + LINE_STEP;
                        end
                        x     <= '0;
                        phase <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture on a reduced 16x6 frame with two skipped frames.
module tb_ov7670_frame_capture;

    localparam int H     = 16;
    localparam int V     = 6;
    localparam int AW    = 7;
    localparam int SK    = 2;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          frame_ok;
    logic          capturing;

    int tests_run = 0;
    int tests_failed = 0;

    int wr_cnt = 0;
    int first_addr = -1;
    int last_addr = -1;
    int addr_bad = 0;
    int data_bad = 0;
    int outside = 0;
    int done_cnt = 0;
    logic last_ok = 1'b0;
    bit chk_data = 1'b1;

    ov7670_frame_capture #(
        .H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .SKIP_FRAMES(SK)
    ) dut (
        .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .capturing(capturing)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix_val(input int y, input int x);
        return 16'(y * 1000 + x * 37 + 4660);
    endfunction

    always @(negedge clk) begin
        if (wr_en) begin
            if (!capturing) outside++;
            if (wr_cnt == 0) first_addr = int'(wr_addr);
            else if (int'(wr_addr) != last_addr + 1) addr_bad++;
            if (chk_data && wr_data !== pix_val(int'(wr_addr) / H, int'(wr_addr) % H)) data_bad++;
            last_addr = int'(wr_addr);
            wr_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            last_ok = frame_ok;
        end
    end

    task automatic clear_stats();
        wr_cnt = 0; first_addr = -1; last_addr = -1; addr_bad = 0;
        data_bad = 0; outside = 0; done_cnt = 0; last_ok = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk); cam_href = 1'b0; cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int y, input int npix, input bit odd);
        logic [15:0] v;
        for (int x = 0; x < npix; x++) begin
            v = pix_val(y, x);
            @(negedge clk); cam_href = 1'b1; cam_data = v[15:8];
            @(negedge clk); cam_data = v[7:0];
        end
        if (odd) begin
            @(negedge clk); cam_data = 8'hEE;
        end
        @(negedge clk); cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines);
        for (int y = 0; y < nlines; y++) send_line(y, H, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        tests_run++; if (wr_data !== 16'h0) begin tests_failed++; $display("FAIL reset_wr_data got %h want 0000", wr_data); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_ok got %b want 0", frame_ok); end
        tests_run++; if (capturing !== 1'b0) begin tests_failed++; $display("FAIL reset_capturing got %b want 0", capturing); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_skip_frames();
        clear_stats();
        vsync_pulse(); send_frame(V);
        vsync_pulse(); send_frame(V);
        vsync_pulse();
        tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL skip_no_writes got %0d want 0", wr_cnt); end
        tests_run++; if (capturing !== 1'b1) begin tests_failed++; $display("FAIL skip_capturing got %b want 1", capturing); end
        send_frame(V);
        vsync_pulse();
        tests_run++; if (wr_cnt !== TOTAL) begin tests_failed++; $display("FAIL full_wr_count got %0d want %0d", wr_cnt, TOTAL); end
        tests_run++; if (last_addr !== TOTAL - 1) begin tests_failed++; $display("FAIL full_last_addr got %0d want %0d", last_addr, TOTAL - 1); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
        tests_run++; if (last_ok !== 1'b1) begin tests_failed++; $display("FAIL full_frame_ok got %b want 1", last_ok); end
        tests_run++; if (data_bad !== 0) begin tests_failed++; $display("FAIL full_data got %0d bad want 0", data_bad); end
        tests_run++; if (addr_bad !== 0) begin tests_failed++; $display("FAIL full_addr_seq got %0d bad want 0", addr_bad); end
        tests_run++; if (outside !== 0) begin tests_failed++; $display("FAIL full_outside got %0d want 0", outside); end
    endtask

    task automatic test_first_pixel();
        clear_stats();
        chk_data = 1'b0;
        @(negedge clk); cam_href = 1'b1; cam_data = 8'hF8;
        @(negedge clk); cam_data = 8'h00;
        @(negedge clk); cam_href = 1'b0; cam_data = 8'h00;
        tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("FAIL first_wr_en got %b want 1", wr_en); end
        tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL first_wr_addr got %0d want 0", wr_addr); end
        tests_run++; if (wr_data !== 16'hF800) begin tests_failed++; $display("FAIL first_wr_data got %h want f800", wr_data); end
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL first_wr_en_drop got %b want 0", wr_en); end
        repeat (3) @(negedge clk);
        vsync_pulse();
        chk_data = 1'b1;
        tests_run++; if (last_ok !== 1'b0) begin tests_failed++; $display("FAIL first_frame_ok got %b want 0", last_ok); end
    endtask

    task automatic test_long_line();
        clear_stats();
        send_line(0, H + 10, 1'b0);
        send_line(1, H, 1'b0);
        tests_run++; if (wr_cnt !== 2 * H) begin tests_failed++; $display("FAIL long_wr_count got %0d want %0d", wr_cnt, 2 * H); end
        tests_run++; if (last_addr !== 2 * H - 1) begin tests_failed++; $display("FAIL long_last_addr got %0d want %0d", last_addr, 2 * H - 1); end
        tests_run++; if (addr_bad !== 0) begin tests_failed++; $display("FAIL long_addr_seq got %0d bad want 0", addr_bad); end
        tests_run++; if (data_bad !== 0) begin tests_failed++; $display("FAIL long_data got %0d bad want 0", data_bad); end
        vsync_pulse();
    endtask

    task automatic test_short_frame();
        clear_stats();
        send_frame(V - 2);
        vsync_pulse();
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL short_done_count got %0d want 1", done_cnt); end
        tests_run++; if (last_ok !== 1'b0) begin tests_failed++; $display("FAIL short_frame_ok got %b want 0", last_ok); end
        tests_run++; if (wr_cnt !== H * (V - 2)) begin tests_failed++; $display("FAIL short_wr_count got %0d want %0d", wr_cnt, H * (V - 2)); end
        clear_stats();
        send_frame(V);
        vsync_pulse();
        tests_run++; if (first_addr !== 0) begin tests_failed++; $display("FAIL restart_first_addr got %0d want 0", first_addr); end
        tests_run++; if (last_ok !== 1'b1) begin tests_failed++; $display("FAIL restart_frame_ok got %b want 1", last_ok); end
        tests_run++; if (wr_cnt !== TOTAL) begin tests_failed++; $display("FAIL restart_wr_count got %0d want %0d", wr_cnt, TOTAL); end
    endtask

    task automatic test_odd_line();
        clear_stats();
        send_line(0, H, 1'b1);
        send_line(1, H, 1'b0);
        tests_run++; if (wr_cnt !== 2 * H) begin tests_failed++; $display("FAIL odd_wr_count got %0d want %0d", wr_cnt, 2 * H); end
        tests_run++; if (data_bad !== 0) begin tests_failed++; $display("FAIL odd_data got %0d bad want 0", data_bad); end
        tests_run++; if (addr_bad !== 0) begin tests_failed++; $display("FAIL odd_addr_seq got %0d bad want 0", addr_bad); end
        tests_run++; if (last_addr !== 2 * H - 1) begin tests_failed++; $display("FAIL odd_last_addr got %0d want %0d", last_addr, 2 * H - 1); end
        vsync_pulse();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        clear_stats();
        send_line(0, H, 1'b0);
        send_line(1, H, 1'b0);
        for (int x = 0; x < 5; x++) begin
            v = pix_val(2, x);
            @(negedge clk); cam_href = 1'b1; cam_data = v[15:8];
            @(negedge clk); cam_data = v[7:0];
        end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_wr_en got %b want 0", wr_en); end
        tests_run++; if (capturing !== 1'b0) begin tests_failed++; $display("FAIL midrst_capturing got %b want 0", capturing); end
        repeat (3) @(negedge clk);
        reset = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        repeat (2) @(negedge clk);
        clear_stats();
        vsync_pulse(); send_frame(V);
        vsync_pulse(); send_frame(V);
        vsync_pulse();
        tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL midrst_skip_writes got %0d want 0", wr_cnt); end
        send_frame(V);
        vsync_pulse();
        tests_run++; if (first_addr !== 0) begin tests_failed++; $display("FAIL midrst_first_addr got %0d want 0", first_addr); end
        tests_run++; if (wr_cnt !== TOTAL) begin tests_failed++; $display("FAIL midrst_wr_count got %0d want %0d", wr_cnt, TOTAL); end
        tests_run++; if (last_ok !== 1'b1) begin tests_failed++; $display("FAIL midrst_frame_ok got %b want 1", last_ok); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL midrst_done_count got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_skip_frames();
        test_first_pixel();
        test_long_line();
        test_short_frame();
        test_odd_line();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
